// File: rtl/accel_spi_scheduler.sv
// Sequencer for an ADXL362-style accelerometer behind a byte-level SPI engine:
// one start-up config write, then paced Y/Z burst reads published as sign-extended samples.
module accel_spi_scheduler #(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned CS_GAP        = 8,
    parameter logic [7:0]  CFG_REG       = 8'h2D,
    parameter logic [7:0]  CFG_VAL       = 8'h02
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        spi_busy,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    output logic        cs_n,
    output logic [15:0] y_data,
    output logic [15:0] z_data,
    output logic        data_valid,
    output logic        cfg_done,
    output logic        overrun
);

    localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned GW = $clog2(CS_GAP + 1);

    localparam logic [2:0] ST_GAP  = 3'd0;
    localparam logic [2:0] ST_CFG  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_UPD  = 3'd4;

    localparam logic [2:0] CFG_BYTES = 3'd3;
    localparam logic [2:0] RD_BYTES  = 3'd6;

    logic [2:0]    state, state_nxt;
    logic [2:0]    byte_idx, byte_nxt;
    logic          pending, pend_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          after_rd, after_nxt;
    logic [7:0]    yl, yl_nxt, zl, zl_nxt;
    logic [3:0]    yh, yh_nxt, zh, zh_nxt;
    logic          start_nxt, cs_n_nxt, dv_nxt, cfg_done_nxt, overrun_nxt;
    logic [7:0]    tx_nxt;
    logic [15:0]   y_nxt, z_nxt;
    logic [PW-1:0] period_cnt;

    logic          tick_c;
    logic          done_c;
    logic [2:0]    idx_c;
    logic [2:0]    last_c;
    logic [7:0]    tx_byte_c;

    // Sample pacing: free-running once configured, tick on wrap
    assign tick_c = cfg_done && (period_cnt == PW'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_cnt <= '0;
        end else if (cfg_done) begin
            period_cnt <= tick_c ? '0 : period_cnt + PW'(1);
        end
    end

    // A done only counts when we have a byte outstanding; idx_c is the byte to issue next
    assign done_c = pending && spi_done;
    assign idx_c  = done_c ? byte_idx + 3'd1 : byte_idx;
    assign last_c = (state == ST_CFG) ? CFG_BYTES : RD_BYTES;

    always_comb begin
        tx_byte_c = 8'h00;
        if (state == ST_CFG) begin
            case (idx_c)
                3'd0:    tx_byte_c = 8'h0A;
                3'd1:    tx_byte_c = CFG_REG;
                default: tx_byte_c = CFG_VAL;
            endcase
        end else begin
            case (idx_c)
                3'd0:    tx_byte_c = 8'h0B;
                3'd1:    tx_byte_c = 8'h10;
                default: tx_byte_c = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_GAP;
            byte_idx   <= '0;
            pending    <= 1'b0;
            gap_cnt    <= '0;
            after_rd   <= 1'b0;
            yl         <= '0;
            yh         <= '0;
            zl         <= '0;
            zh         <= '0;
            spi_start  <= 1'b0;
            spi_tx     <= '0;
            cs_n       <= 1'b1;
            y_data     <= '0;
            z_data     <= '0;
            data_valid <= 1'b0;
            cfg_done   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_idx   <= byte_nxt;
            pending    <= pend_nxt;
            gap_cnt    <= gap_nxt;
            after_rd   <= after_nxt;
            yl         <= yl_nxt;
            yh         <= yh_nxt;
            zl         <= zl_nxt;
            zh         <= zh_nxt;
            spi_start  <= start_nxt;
            spi_tx     <= tx_nxt;
            cs_n       <= cs_n_nxt;
            y_data     <= y_nxt;
            z_data     <= z_nxt;
            data_valid <= dv_nxt;
            cfg_done   <= cfg_done_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_nxt     = byte_idx;
        pend_nxt     = pending;
        gap_nxt      = gap_cnt;
        after_nxt    = after_rd;
        yl_nxt       = yl;
        yh_nxt       = yh;
        zl_nxt       = zl;
        zh_nxt       = zh;
        start_nxt    = 1'b0;
        tx_nxt       = spi_tx;
        cs_n_nxt     = cs_n;
        y_nxt        = y_data;
        z_nxt        = z_data;
        dv_nxt       = 1'b0;
        cfg_done_nxt = cfg_done;
        overrun_nxt  = overrun;

        // Ticks that land on a read still in flight are flagged and dropped
        if (tick_c && (state == ST_RD || state == ST_UPD || (state == ST_GAP && after_rd))) begin
            overrun_nxt = 1'b1;
        end

        case (state)
            ST_GAP: begin
                cs_n_nxt = 1'b1;
                if (gap_cnt == GW'(CS_GAP - 1)) begin
                    gap_nxt   = '0;
                    after_nxt = 1'b0;
                    byte_nxt  = '0;
                    pend_nxt  = 1'b0;
                    if (cfg_done) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_CFG;
                        cs_n_nxt  = 1'b0;
                    end
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            ST_WAIT: begin
                if (tick_c && en) begin
                    state_nxt = ST_RD;
                    cs_n_nxt  = 1'b0;
                    byte_nxt  = '0;
                    pend_nxt  = 1'b0;
                end
            end
            ST_CFG, ST_RD: begin
                if (done_c) begin
                    byte_nxt = idx_c;
                    pend_nxt = 1'b0;
                    if (state == ST_RD) begin
                        case (byte_idx)
                            3'd2:    yl_nxt = spi_rx;
                            3'd3:    yh_nxt = spi_rx[3:0];
                            3'd4:    zl_nxt = spi_rx;
                            3'd5:    zh_nxt = spi_rx[3:0];
                            default: ;
                        endcase
                    end
                end
                if (done_c && idx_c == last_c) begin
                    cs_n_nxt = 1'b1;
                    if (state == ST_CFG) begin
                        cfg_done_nxt = 1'b1;
                        state_nxt    = ST_GAP;
                        gap_nxt      = '0;
                    end else begin
                        state_nxt = ST_UPD;
                    end
                end else if ((!pending || done_c) && !spi_busy) begin
                    start_nxt = 1'b1;
                    tx_nxt    = tx_byte_c;
                    pend_nxt  = 1'b1;
                end
            end
            ST_UPD: begin
                y_nxt     = {{4{yh[3]}}, yh, yl};
                z_nxt     = {{4{zh[3]}}, zh, zl};
                dv_nxt    = 1'b1;
                state_nxt = ST_GAP;
                gap_nxt   = '0;
                after_nxt = 1'b1;
            end
            default: begin
                state_nxt = ST_GAP;
            end
        endcase
    end

endmodule

// File: tb/tb_accel_spi_scheduler.sv
// Directed bench: two schedulers (normal pacing and a fast period that must overrun),
// each driven by a 16-clock/byte SPI engine model.
`timescale 1ns/1ps
module tb_accel_spi_scheduler;

    localparam int unsigned P0  = 300;
    localparam int unsigned P1  = 64;
    localparam int unsigned GAP = 8;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        en [2]       = '{1'b0, 1'b1};
    logic        spi_busy [2] = '{1'b0, 1'b0};
    logic        spi_done [2] = '{1'b0, 1'b0};
    logic [7:0]  spi_rx [2]   = '{8'h00, 8'h00};
    logic        spi_start [2];
    logic [7:0]  spi_tx [2];
    logic        cs_n [2];
    logic [15:0] y_data [2];
    logic [15:0] z_data [2];
    logic        data_valid [2];
    logic        cfg_done [2];
    logic        overrun [2];

    int total = 0;
    int bad   = 0;

    accel_spi_scheduler #(.SAMPLE_PERIOD(P0), .CS_GAP(GAP)) dut0 (
        .clk(clk), .resetn(resetn), .en(en[0]),
        .spi_busy(spi_busy[0]), .spi_done(spi_done[0]), .spi_rx(spi_rx[0]),
        .spi_start(spi_start[0]), .spi_tx(spi_tx[0]), .cs_n(cs_n[0]),
        .y_data(y_data[0]), .z_data(z_data[0]), .data_valid(data_valid[0]),
        .cfg_done(cfg_done[0]), .overrun(overrun[0])
    );

    accel_spi_scheduler #(.SAMPLE_PERIOD(P1), .CS_GAP(GAP)) dut1 (
        .clk(clk), .resetn(resetn), .en(en[1]),
        .spi_busy(spi_busy[1]), .spi_done(spi_done[1]), .spi_rx(spi_rx[1]),
        .spi_start(spi_start[1]), .spi_tx(spi_tx[1]), .cs_n(cs_n[1]),
        .y_data(y_data[1]), .z_data(z_data[1]), .data_valid(data_valid[1]),
        .cfg_done(cfg_done[1]), .overrun(overrun[1])
    );

    always #5 clk = ~clk;

    // SPI engine model: 16 clocks busy per byte, done coincides with busy falling
    int         bcnt [2]      = '{0, 0};
    int         cur_idx [2]   = '{0, 0};
    int         nbyte [2]     = '{0, 0};
    int         tx_n [2]      = '{0, 0};
    int         proto_err [2] = '{0, 0};
    logic [7:0] tx_hold [2]   = '{8'h00, 8'h00};
    logic [7:0] tx_log [2][256];
    logic [7:0] rx_tab [6];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            spi_done[u] <= 1'b0;
            if ((spi_start[u] && (spi_busy[u] || cs_n[u])) ||
                (resetn && spi_busy[u] && spi_tx[u] !== tx_hold[u]))
                proto_err[u] <= proto_err[u] + 1;
            if (cs_n[u]) nbyte[u] <= 0;
            if (!resetn) tx_hold[u] <= 8'h00;
            if (spi_start[u] && !spi_busy[u]) begin
                spi_busy[u] <= 1'b1;
                bcnt[u]     <= 16;
                cur_idx[u]  <= nbyte[u];
                nbyte[u]    <= nbyte[u] + 1;
                tx_hold[u]  <= spi_tx[u];
                tx_log[u][tx_n[u] % 256] <= spi_tx[u];
                tx_n[u]     <= tx_n[u] + 1;
            end else if (spi_busy[u]) begin
                bcnt[u] <= bcnt[u] - 1;
                if (bcnt[u] == 1) begin
                    spi_busy[u] <= 1'b0;
                    spi_done[u] <= 1'b1;
                    spi_rx[u]   <= (u == 0 && cur_idx[0] < 6) ? rx_tab[cur_idx[0]] : 8'h00;
                end
            end
        end
    end

    // Observation counters sampled on the falling edge
    int   cyc = 0;
    int   nfall [2]     = '{0, 0};
    int   last_fall [2] = '{0, 0};
    int   ndv [2]       = '{0, 0};
    int   dv_wide       = 0;
    logic prev_cs [2]   = '{1'b1, 1'b1};
    logic prev_dv [2]   = '{1'b0, 1'b0};

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int u = 0; u < 2; u++) begin
            if (prev_cs[u] === 1'b1 && cs_n[u] === 1'b0) begin
                last_fall[u] = cyc;
                nfall[u]     = nfall[u] + 1;
            end
            prev_cs[u] = cs_n[u];
            if (data_valid[u] === 1'b1) begin
                ndv[u] = ndv[u] + 1;
                if (prev_dv[u] === 1'b1) dv_wide = dv_wide + 1;
            end
            prev_dv[u] = data_valid[u];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fall(input int u, input int limit, output bit ok);
        int nf;
        nf = nfall[u];
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (nfall[u] != nf) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_dv(input int u, input int limit, output bit ok);
        int nd;
        nd = ndv[u];
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (ndv[u] != nd) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_cfg(input int u, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (cfg_done[u] === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_txn(input int u, input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (tx_n[u] >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        total++;
        if ({spi_start[0], cs_n[0], data_valid[0], cfg_done[0], overrun[0]} !== 5'b01000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 01000",
                     {spi_start[0], cs_n[0], data_valid[0], cfg_done[0], overrun[0]});
        end
        total++;
        if ({spi_tx[0], y_data[0], z_data[0]} !== 40'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {spi_tx[0], y_data[0], z_data[0]});
        end
        total++;
        if (cs_n[1] !== 1'b1 || tx_n[0] !== 0) begin
            bad++;
            $display("FAIL reset_no_start: got cs_n1=%b starts=%0d want 1/0", cs_n[1], tx_n[0]);
        end
    endtask

    task automatic test_config();
        int base;
        int nf;
        bit ok;
        base = tx_n[0];
        nf   = nfall[0];
        resetn = 1'b1;
        wait_cfg(0, 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL cfg_timeout: got cfg_done=%b want 1", cfg_done[0]); end
        total++;
        if (tx_n[0] - base !== 3) begin
            bad++;
            $display("FAIL cfg_count: got %0d want 3", tx_n[0] - base);
        end
        total++;
        if ({tx_log[0][base % 256], tx_log[0][(base + 1) % 256], tx_log[0][(base + 2) % 256]} !== 24'h0A2D02) begin
            bad++;
            $display("FAIL cfg_bytes: got %h want 0a2d02",
                     {tx_log[0][base % 256], tx_log[0][(base + 1) % 256], tx_log[0][(base + 2) % 256]});
        end
        total++;
        if (nfall[0] - nf !== 1 || cs_n[0] !== 1'b1 || spi_busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL cfg_single_cs: got falls=%0d cs_n=%b busy=%b want 1/1/0",
                     nfall[0] - nf, cs_n[0], spi_busy[0]);
        end
        repeat (2 * P0 + 50) step();
        total++;
        if (tx_n[0] - base !== 3 || nfall[0] - nf !== 1 || cs_n[0] !== 1'b1 || overrun[0] !== 1'b0) begin
            bad++;
            $display("FAIL cfg_idle_en0: got starts=%0d falls=%0d cs_n=%b ovr=%b want 3/1/1/0",
                     tx_n[0] - base, nfall[0] - nf, cs_n[0], overrun[0]);
        end
    endtask

    task automatic test_read();
        int base;
        int d0;
        int f1;
        bit ok;
        rx_tab = '{8'hEE, 8'hEE, 8'h34, 8'h02, 8'hFF, 8'h0F};
        base = tx_n[0];
        d0   = ndv[0];
        en[0] = 1'b1;
        wait_dv(0, P0 + 200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL read_timeout: got dv_count=%0d want %0d", ndv[0], d0 + 1); end
        total++;
        if (y_data[0] !== 16'h0234 || z_data[0] !== 16'hFFFF) begin
            bad++;
            $display("FAIL read_data: got y=%h z=%h want 0234/ffff", y_data[0], z_data[0]);
        end
        total++;
        if (tx_n[0] - base !== 6 ||
            {tx_log[0][base % 256], tx_log[0][(base + 1) % 256], tx_log[0][(base + 2) % 256],
             tx_log[0][(base + 3) % 256], tx_log[0][(base + 4) % 256], tx_log[0][(base + 5) % 256]} !== 48'h0B1000000000) begin
            bad++;
            $display("FAIL read_bytes: got n=%0d %h %h want 6 0b10 0000",
                     tx_n[0] - base, tx_log[0][base % 256], tx_log[0][(base + 1) % 256]);
        end
        step();
        total++;
        if (data_valid[0] !== 1'b0 || y_data[0] !== 16'h0234 || ndv[0] - d0 !== 1) begin
            bad++;
            $display("FAIL read_pulse: got dv=%b y=%h count=%0d want 0/0234/1",
                     data_valid[0], y_data[0], ndv[0] - d0);
        end
        f1 = last_fall[0];
        wait_fall(0, P0 + 50, ok);
        total++;
        if (!ok || last_fall[0] - f1 !== P0) begin
            bad++;
            $display("FAIL read_period: got %0d want %0d", last_fall[0] - f1, P0);
        end
        wait_dv(0, 200, ok);
        total++;
        if (!ok || overrun[0] !== 1'b0 || ndv[0] - d0 !== 2) begin
            bad++;
            $display("FAIL read_second: got ok=%b ovr=%b count=%0d want 1/0/2", ok, overrun[0], ndv[0] - d0);
        end
    endtask

    task automatic test_overrun();
        int d1;
        int fa;
        bit ok;
        total++;
        if (overrun[1] !== 1'b1 || cfg_done[1] !== 1'b1) begin
            bad++;
            $display("FAIL ovr_flag: got ovr=%b cfg=%b want 1/1", overrun[1], cfg_done[1]);
        end
        d1 = ndv[1];
        wait_fall(1, 200, ok);
        fa = last_fall[1];
        wait_fall(1, 200, ok);
        total++;
        if (!ok || last_fall[1] - fa !== 2 * P1) begin
            bad++;
            $display("FAIL ovr_no_queue: got %0d want %0d", last_fall[1] - fa, 2 * P1);
        end
        total++;
        if ((ndv[1] - d1 >= 1) !== 1'b1 || overrun[0] !== 1'b0) begin
            bad++;
            $display("FAIL ovr_continue: got reads=%0d ovr0=%b want >=1/0", ndv[1] - d1, overrun[0]);
        end
    endtask

    task automatic test_en_drop();
        int base;
        int d0;
        int nf;
        bit ok;
        wait_fall(0, P0 + 50, ok);
        rx_tab = '{8'hEE, 8'hEE, 8'hCD, 8'h0A, 8'h78, 8'h05};
        base = tx_n[0];
        d0   = ndv[0];
        wait_txn(0, base + 3, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL endrop_start: got starts=%0d want 3", tx_n[0] - base); end
        en[0] = 1'b0;
        wait_dv(0, 200, ok);
        total++;
        if (!ok || y_data[0] !== 16'hFACD || z_data[0] !== 16'h0578 || tx_n[0] - base !== 6) begin
            bad++;
            $display("FAIL endrop_data: got y=%h z=%h n=%0d want facd/0578/6", y_data[0], z_data[0], tx_n[0] - base);
        end
        nf = nfall[0];
        repeat (2 * P0 + 50) step();
        total++;
        if (nfall[0] !== nf || ndv[0] - d0 !== 1 || cs_n[0] !== 1'b1 || overrun[0] !== 1'b0) begin
            bad++;
            $display("FAIL endrop_idle: got falls=%0d dv=%0d cs_n=%b ovr=%b want 0/1/1/0",
                     nfall[0] - nf, ndv[0] - d0, cs_n[0], overrun[0]);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        en[0] = 1'b1;
        wait_fall(0, P0 + 50, ok);
        base = tx_n[0];
        wait_txn(0, base + 3, 100, ok);
        repeat (3) step();
        total++;
        if (!ok || cs_n[0] !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_active: got ok=%b cs_n=%b want 1/0", ok, cs_n[0]);
        end
        resetn = 1'b0;
        #1;
        total++;
        if (cs_n[0] !== 1'b1 || cfg_done[0] !== 1'b0 || spi_start[0] !== 1'b0 || y_data[0] !== 16'h0) begin
            bad++;
            $display("FAIL rstmid_async: got cs_n=%b cfg=%b start=%b y=%h want 1/0/0/0000",
                     cs_n[0], cfg_done[0], spi_start[0], y_data[0]);
        end
        en[0] = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        base = tx_n[0];
        wait_cfg(0, 400, ok);
        total++;
        if (!ok || tx_n[0] - base !== 3 ||
            {tx_log[0][base % 256], tx_log[0][(base + 1) % 256], tx_log[0][(base + 2) % 256]} !== 24'h0A2D02) begin
            bad++;
            $display("FAIL rstmid_recfg: got ok=%b n=%0d bytes=%h want 1/3/0a2d02", ok, tx_n[0] - base,
                     {tx_log[0][base % 256], tx_log[0][(base + 1) % 256], tx_log[0][(base + 2) % 256]});
        end
    endtask

    task automatic test_protocol();
        total++;
        if (proto_err[0] !== 0 || proto_err[1] !== 0 || dv_wide !== 0) begin
            bad++;
            $display("FAIL protocol: got err0=%0d err1=%0d wide_dv=%0d want 0/0/0",
                     proto_err[0], proto_err[1], dv_wide);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_read();
        test_overrun();
        test_en_drop();
        test_reset_mid();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
